// File: rtl/ro_mon_pkg.sv
// Shared types and default parameters for the ring-oscillator frequency monitor.
package ro_mon_pkg;

    localparam int unsigned DEF_WINDOW_CYCLES = 1024;
    localparam int unsigned DEF_SETTLE_CYCLES = 16;
    localparam int unsigned DEF_CNT_W         = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        REPORT  = 2'd3
    } state_e;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module ro_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;

    // Next-state: shift the async input through the chain and flag 0->1 transitions.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise_d  = sync2_q & ~prev_q;
    end

    // Synchronizer and detector flops, synchronously cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_pulse = rise_q;

endmodule

// File: rtl/ro_freq_monitor.sv
// Counts ring-oscillator rising edges over a fixed clk window and flags overspeed.
module ro_freq_monitor
    import ro_mon_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic [CNT_W-1:0] thresh,
    input  logic             clear_alarm,
    input  logic             ro_in,
    output logic             ro_enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             alarm
);

    localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e           state_q,     state_d;
    logic [SET_W-1:0] set_cnt_q,   set_cnt_d;
    logic [WIN_W-1:0] win_cnt_q,   win_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q,  edge_cnt_d;
    logic [CNT_W-1:0] thresh_q,    thresh_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             done_q,      done_d;
    logic             alarm_q,     alarm_d;
    logic             ro_enable_q, ro_enable_d;
    logic             busy_q,      busy_d;

    logic             rise_pulse;
    logic [CNT_W-1:0] edge_next_c;
    logic             alarm_set_c;

    ro_edge_sync u_edge_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (ro_in),
        .rise_pulse (rise_pulse)
    );

    // FSM next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        set_cnt_d   = set_cnt_q;
        win_cnt_d   = win_cnt_q;
        edge_cnt_d  = edge_cnt_q;
        thresh_d    = thresh_q;
        count_d     = count_q;
        done_d      = 1'b0;
        alarm_d     = alarm_q;
        alarm_set_c = 1'b0;

        // Saturating increment; the final window cycle's edge is folded into the report.
        edge_next_c = edge_cnt_q;
        if (rise_pulse && (edge_cnt_q != CNT_MAX)) begin
            edge_next_c = edge_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SETTLE;
                    set_cnt_d = '0;
                end
            end
            SETTLE: begin
                if (set_cnt_q == SET_LAST) begin
                    state_d    = MEASURE;
                    win_cnt_d  = '0;
                    edge_cnt_d = '0;
                    thresh_d   = thresh;
                end else begin
                    set_cnt_d = set_cnt_q + SET_W'(1);
                end
            end
            MEASURE: begin
                edge_cnt_d = edge_next_c;
                if (win_cnt_q == WIN_LAST) begin
                    state_d     = REPORT;
                    count_d     = edge_next_c;
                    done_d      = 1'b1;
                    alarm_set_c = (edge_next_c > thresh_q);
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end
            REPORT: begin
                if (continuous) begin
                    state_d    = MEASURE;
                    win_cnt_d  = '0;
                    edge_cnt_d = '0;
                    thresh_d   = thresh;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Sticky alarm: a new set takes priority over a simultaneous clear.
        if (clear_alarm) begin
            alarm_d = 1'b0;
        end
        if (alarm_set_c) begin
            alarm_d = 1'b1;
        end

        ro_enable_d = (state_d != IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            set_cnt_q   <= '0;
            win_cnt_q   <= '0;
            edge_cnt_q  <= '0;
            thresh_q    <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
            ro_enable_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            set_cnt_q   <= set_cnt_d;
            win_cnt_q   <= win_cnt_d;
            edge_cnt_q  <= edge_cnt_d;
            thresh_q    <= thresh_d;
            count_q     <= count_d;
            done_q      <= done_d;
            alarm_q     <= alarm_d;
            ro_enable_q <= ro_enable_d;
            busy_q      <= busy_d;
        end
    end

    assign ro_enable = ro_enable_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_ro_freq_monitor.sv
// Scoreboard-based bench for ro_freq_monitor: default build plus a narrow-counter build.
module tb_ro_freq_monitor;

    logic        clk;
    logic        rst_n;
    logic        start, continuous, clear_alarm, ro_in;
    logic [15:0] thresh;
    logic        ro_enable, busy, done, alarm;
    logic [15:0] count;

    logic        start4, cont4, clr4, ro4;
    logic [3:0]  thresh4;
    logic        ro_en4, busy4, done4, alarm4;
    logic [3:0]  count4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int lo;
        int hi;
        bit alarm;
    } exp_t;
    exp_t sb_q[$];

    ro_freq_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .continuous  (continuous),
        .thresh      (thresh),
        .clear_alarm (clear_alarm),
        .ro_in       (ro_in),
        .ro_enable   (ro_enable),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .alarm       (alarm)
    );

    ro_freq_monitor #(
        .WINDOW_CYCLES (128),
        .SETTLE_CYCLES (16),
        .CNT_W         (4)
    ) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start4),
        .continuous  (cont4),
        .thresh      (thresh4),
        .clear_alarm (clr4),
        .ro_in       (ro4),
        .ro_enable   (ro_en4),
        .busy        (busy4),
        .done        (done4),
        .count       (count4),
        .alarm       (alarm4)
    );

    // 10 ns clk; oscillators at 8 and 4 clk periods, offset from clk edges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ro_in = 1'b0;
        #3;
        forever #40 ro_in = ~ro_in;
    end

    initial begin
        ro4 = 1'b0;
        #7;
        forever #20 ro4 = ~ro4;
    end

    // Waits for done (or done4); cyc is the negedge index after the start edge, -1 on timeout.
    task automatic wait_done(input bit use4, input int limit, output int cyc);
        cyc = 1;
        while (cyc <= limit) begin
            if ((use4 ? done4 : done) === 1'b1) return;
            @(negedge clk);
            cyc++;
        end
        cyc = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; continuous = 0; clear_alarm = 0; thresh = '0;
        start4 = 0; cont4 = 0; clr4 = 0; thresh4 = '0;
        repeat (3) @(negedge clk);
        checks++; if (ro_enable !== 1'b0) begin errors++; $display("FAIL reset_ro_enable got=%b want=0", ro_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%b want=0", alarm); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        exp_t e;
        int   cyc;
        thresh = 16'd200;
        sb_q.push_back('{127, 129, 1'b0});
        pulse_start();
        wait_done(1'b0, 1200, cyc);
        checks++; if (cyc !== 1041) begin errors++; $display("FAIL single_latency got=%0d want=1041", cyc); end
        e = sb_q.pop_front();
        checks++; if (int'(count) < e.lo || int'(count) > e.hi) begin errors++; $display("FAIL single_count got=%0d want=%0d..%0d", count, e.lo, e.hi); end
        checks++; if (alarm !== e.alarm) begin errors++; $display("FAIL single_alarm got=%b want=%b", alarm, e.alarm); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_report got=%b want=1", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%b want=0", done); end
        checks++; if (busy !== 1'b0 || ro_enable !== 1'b0) begin errors++; $display("FAIL single_idle busy=%b ro_enable=%b want=0,0", busy, ro_enable); end
        repeat (5) @(negedge clk);
        checks++; if (int'(count) < e.lo || int'(count) > e.hi) begin errors++; $display("FAIL single_count_hold got=%0d want=%0d..%0d", count, e.lo, e.hi); end
    endtask

    task automatic test_alarm();
        exp_t e;
        int   cyc;
        thresh = 16'd100;
        sb_q.push_back('{127, 129, 1'b1});
        pulse_start();
        wait_done(1'b0, 1200, cyc);
        checks++; if (cyc !== 1041) begin errors++; $display("FAIL alarm_latency got=%0d want=1041", cyc); end
        e = sb_q.pop_front();
        checks++; if (int'(count) < e.lo || int'(count) > e.hi) begin errors++; $display("FAIL alarm_count got=%0d want=%0d..%0d", count, e.lo, e.hi); end
        checks++; if (alarm !== e.alarm) begin errors++; $display("FAIL alarm_set got=%b want=%b", alarm, e.alarm); end
        repeat (5) @(negedge clk);
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_sticky got=%b want=1", alarm); end
        clear_alarm = 1'b1;
        @(negedge clk);
        clear_alarm = 1'b0;
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_clear got=%b want=0", alarm); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_no_start got=%b want=0", busy); end
    endtask

    task automatic test_saturate();
        exp_t e;
        int   cyc;
        thresh4 = 4'd10;
        sb_q.push_back('{15, 15, 1'b1});
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done(1'b1, 300, cyc);
        checks++; if (cyc !== 145) begin errors++; $display("FAIL sat_latency got=%0d want=145", cyc); end
        e = sb_q.pop_front();
        checks++; if (int'(count4) < e.lo || int'(count4) > e.hi) begin errors++; $display("FAIL sat_count got=%0d want=%0d", count4, e.lo); end
        checks++; if (alarm4 !== e.alarm) begin errors++; $display("FAIL sat_alarm got=%b want=%b", alarm4, e.alarm); end
        @(negedge clk);
        checks++; if (busy4 !== 1'b0 || ro_en4 !== 1'b0) begin errors++; $display("FAIL sat_idle busy=%b ro_enable=%b want=0,0", busy4, ro_en4); end
    endtask

    task automatic test_continuous();
        exp_t e;
        int   cyc;
        int   en_bad;
        bit   got;
        thresh     = 16'd200;
        continuous = 1'b1;
        en_bad     = 0;
        for (int w = 0; w < 3; w++) sb_q.push_back('{127, 129, 1'b0});
        pulse_start();
        for (int w = 0; w < 3; w++) begin
            cyc = (w == 0) ? 1 : 0;
            got = 1'b0;
            while (cyc < 1100 && !got) begin
                @(negedge clk);
                cyc++;
                if (w == 2 && cyc == 10) continuous = 1'b0;
                if (ro_enable !== 1'b1) en_bad++;
                if (done === 1'b1) got = 1'b1;
            end
            checks++;
            if (!got || cyc !== ((w == 0) ? 1041 : 1025)) begin
                errors++;
                $display("FAIL cont_period_%0d got=%0d seen=%b want=%0d", w, cyc, got, (w == 0) ? 1041 : 1025);
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++; if (int'(count) < e.lo || int'(count) > e.hi) begin errors++; $display("FAIL cont_count_%0d got=%0d want=%0d..%0d", w, count, e.lo, e.hi); end
            end
        end
        checks++; if (en_bad !== 0) begin errors++; $display("FAIL cont_ro_enable low_cycles=%0d want=0", en_bad); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ro_enable !== 1'b0) begin errors++; $display("FAIL cont_stop busy=%b ro_enable=%b want=0,0", busy, ro_enable); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        bit   got;
        thresh      = 16'd100;
        continuous  = 1'b0;
        sb_q.push_back('{127, 129, 1'b1});
        pulse_start();
        cyc = 1;
        got = 1'b0;
        while (cyc < 1200 && !got) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 5 || cyc == 100 || cyc == 600) ? 1'b1 : 1'b0;
            if (cyc >= 1000) clear_alarm = 1'b1;
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        checks++; if (!got || cyc !== 1041) begin errors++; $display("FAIL b2b_latency got=%0d seen=%b want=1041", cyc, got); end
        e = sb_q.pop_front();
        checks++; if (int'(count) < e.lo || int'(count) > e.hi) begin errors++; $display("FAIL b2b_count got=%0d want=%0d..%0d", count, e.lo, e.hi); end
        checks++; if (alarm !== e.alarm) begin errors++; $display("FAIL b2b_set_wins got=%b want=%b", alarm, e.alarm); end
        clear_alarm = 1'b0;
        @(negedge clk);
        checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL b2b_alarm_hold got=%b want=1", alarm); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_starts_ignored busy=%b want=0", busy); end
    endtask

    task automatic test_reset_mid_measure();
        bit seen;
        thresh = 16'd200;
        pulse_start();
        repeat (16 + 500) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (ro_enable !== 1'b0) begin errors++; $display("FAIL rstmid_ro_enable got=%b want=0", ro_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL rstmid_count got=%0d want=0", count); end
        checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL rstmid_alarm got=%b want=0", alarm); end
        seen = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got=%b want=0", seen); end
        checks++; if (count !== 16'd0) begin errors++; $display("FAIL rstmid_count_after got=%0d want=0", count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alarm();
        test_saturate();
        test_continuous();
        test_back_to_back();
        test_reset_mid_measure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
